seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 171 +++++++++++++++++
 tb/tb_seg_scan_driver.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit 7-segment scan driver with blanking and frame-synchronous data update.
// Latency: all outputs registered; one cycle from Enable/Load/RST to the outputs.
// No backpressure: Load is a one-shot strobe; a pending update is applied at the next frame start.
// Optional build macro: SEG_LZB_EN enables leading-zero blanking on the copy into the shadow register.
module seg_scan_driver #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Enable,
    input  logic       Load,
    input  logic [6:0] dg1,
    input  logic [6:0] dg2,
    input  logic [6:0] dg3,
    input  logic [6:0] dg4,
    output logic [6:0] Seg,
    output logic [3:0] Anode,
    output logic       FrameSync,
    output logic       Pending
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    // Index 0 holds dg1 (rightmost digit), index 3 holds dg4.
    typedef logic [3:0][6:0] digits_t;

    // Applied only on the way into the shadow; staging always keeps the raw patterns.
    function automatic digits_t blank_lz(input digits_t d);
`ifdef SEG_LZB_EN
        digits_t r;
        logic    b4;
        logic    b3;
        r  = d;
        b4 = (d[3] == 7'b1000000);
        b3 = b4 && (d[2] == 7'b1000000);
        if (b4) r[3] = 7'h7F;
        if (b3) r[2] = 7'h7F;
        if (b3 && (d[1] == 7'b1000000)) r[1] = 7'h7F;
        return r;
`else
        return d;
`endif
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    digits_t          stage_q, stage_d;
    digits_t          shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       anode_q, anode_d;
    logic             fsync_q, fsync_d;
    logic             frame_start;
    digits_t          dg_in;

    assign dg_in = {dg4, dg3, dg2, dg1};

    // State register: reset dominates everything, including Enable and Load.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            stage_q   <= {4{7'h7F}};
            shadow_q  <= {4{7'h7F}};
            pending_q <= 1'b0;
            seg_q     <= 7'h7F;
            anode_q   <= 4'hF;
            fsync_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            stage_q   <= stage_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            anode_q   <= anode_d;
            fsync_q   <= fsync_d;
        end
    end

    // Next-state: slot timing, digit index, and staging/shadow double buffering.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        stage_d     = stage_q;
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        frame_start = 1'b0;

        if (!Enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_BLANK;
                    cnt_d       = '0;
                    idx_d       = '0;
                    frame_start = 1'b1;
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
                    cnt_d = cnt_q + 1'b1;
                end
                ST_SHOW: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_d     = ST_BLANK;
                        cnt_d       = '0;
                        idx_d       = idx_q + 2'd1;
                        frame_start = (idx_q == 2'd3);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end

        if (Load && (state_q == ST_IDLE)) begin
            // Display is dark, so new data can go straight to the shadow.
            stage_d   = dg_in;
            shadow_d  = blank_lz(dg_in);
            pending_d = 1'b0;
        end else begin
            // Old staged data moves first; a coincident Load then restages and keeps Pending set.
            if (frame_start && pending_q) begin
                shadow_d  = blank_lz(stage_q);
                pending_d = 1'b0;
            end
            if (Load) begin
                stage_d   = dg_in;
                pending_d = 1'b1;
            end
        end
    end

    // Output decode from next-state values so the registered outputs line up with the state.
    always_comb begin
        fsync_d = frame_start;
        anode_d = 4'hF;
        seg_d   = 7'h7F;
        if (state_d == ST_SHOW) begin
            anode_d = ~(4'b0001 << idx_d);
            seg_d   = shadow_d[idx_d];
        end
    end

    assign Seg       = seg_q;
    assign Anode     = anode_q;
    assign FrameSync = fsync_q;
    assign Pending   = pending_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with CLK_DIV=8, BLANK_CYC=2 (32-cycle frame).
// Latency: outputs sampled 1 time unit after each rising edge.
// No backpressure: stimulus strobes Load/Enable/RST directly.
module tb_seg_scan_driver;

    typedef logic [3:0][6:0] pat_t;

    logic       CLK;
    logic       RST;
    logic       Enable;
    logic       Load;
    logic [6:0] dg1, dg2, dg3, dg4;
    logic [6:0] Seg;
    logic [3:0] Anode;
    logic       FrameSync;
    logic       Pending;

    int checks   = 0;
    int failures = 0;

    seg_scan_driver #(.CLK_DIV(8), .BLANK_CYC(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Enable    (Enable),
        .Load      (Load),
        .dg1       (dg1),
        .dg2       (dg2),
        .dg3       (dg3),
        .dg4       (dg4),
        .Seg       (Seg),
        .Anode     (Anode),
        .FrameSync (FrameSync),
        .Pending   (Pending)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic pat_t mk(input logic [6:0] d1, input logic [6:0] d2,
                                input logic [6:0] d3, input logic [6:0] d4);
        return {d4, d3, d2, d1};
    endfunction

    task automatic drive_dg(input pat_t p);
        dg1 = p[0];
        dg2 = p[1];
        dg3 = p[2];
        dg4 = p[3];
    endtask

    // Walks one full frame starting at its FrameSync cycle (already sampled),
    // checking every cycle; optional Load strobes at cycles l1 and l2 (99 = none).
    // Pending is expected to be pend0 up to cycle l1 and 1 afterwards.
    task automatic frame(input string tag, input pat_t pats, input logic pend0,
                         input int l1, input pat_t d1, input int l2, input pat_t d2);
        for (int c = 0; c < 32; c++) begin
            int         slot;
            int         off;
            logic [3:0] an_exp;
            logic [6:0] seg_exp;
            if (c > 0) step();
            slot    = c / 8;
            off     = c % 8;
            an_exp  = (off < 2) ? 4'hF : ~(4'b0001 << slot);
            seg_exp = (off < 2) ? 7'h7F : pats[slot];
            check($sformatf("%s c%0d fsync", tag, c), 32'(FrameSync), 32'(c == 0));
            check($sformatf("%s c%0d anode", tag, c), 32'(Anode), 32'(an_exp));
            check($sformatf("%s c%0d seg", tag, c), 32'(Seg), 32'(seg_exp));
            check($sformatf("%s c%0d pending", tag, c), 32'(Pending),
                  32'((c <= l1) ? pend0 : 1'b1));
            Load = (c == l1) || (c == l2);
            if (c == l1) drive_dg(d1);
            if (c == l2) drive_dg(d2);
        end
    endtask

    pat_t pa, pb, pc, pd, pe, pf, pblank, plz, plz_exp, pnone;

    initial begin
        pa     = mk(7'h79, 7'h24, 7'h30, 7'h19);
        pb     = mk(7'h40, 7'h79, 7'h24, 7'h30);
        pc     = mk(7'h12, 7'h02, 7'h78, 7'h00);
        pd     = mk(7'h10, 7'h08, 7'h03, 7'h46);
        pe     = mk(7'h21, 7'h06, 7'h0E, 7'h7E);
        pf     = mk(7'h3F, 7'h11, 7'h22, 7'h44);
        pblank = mk(7'h7F, 7'h7F, 7'h7F, 7'h7F);
        pnone  = mk(7'h00, 7'h00, 7'h00, 7'h00);
        plz    = mk(7'h40, 7'h79, 7'h40, 7'h40);
`ifdef SEG_LZB_EN
        plz_exp = mk(7'h40, 7'h79, 7'h7F, 7'h7F);
`else
        plz_exp = plz;
`endif

        RST    = 1'b1;
        Enable = 1'b0;
        Load   = 1'b0;
        drive_dg(pnone);
        step();
        step();
        check("rst anode", 32'(Anode), 32'h0F);
        check("rst seg", 32'(Seg), 32'h7F);
        check("rst fsync", 32'(FrameSync), 32'h0);
        check("rst pending", 32'(Pending), 32'h0);

        // Load and Enable together in IDLE: first frame must already show A.
        RST    = 1'b0;
        Load   = 1'b1;
        Enable = 1'b1;
        drive_dg(pa);
        step();
        frame("f1", pa, 1'b0, 99, pnone, 99, pnone);
        step();
        // Load mid idx 1 slot: current frame keeps A.
        frame("f2", pa, 1'b0, 12, pb, 99, pnone);
        step();
        // Load C mid-frame, then D exactly on the frame-start edge.
        frame("f3", pb, 1'b0, 5, pc, 31, pd);
        step();
        // Shadow got C, D still staged.
        frame("f4", pc, 1'b1, 99, pnone, 99, pnone);
        step();
        // Two loads in one frame: last write wins.
        frame("f5", pd, 1'b0, 3, pe, 10, pf);
        step();
        check("f6 fsync", 32'(FrameSync), 32'h1);
        for (int i = 0; i < 20; i++) step();
        check("f6 c20 anode", 32'(Anode), 32'h0B);
        check("f6 c20 seg", 32'(Seg), 32'(pf[2]));

        // Reset during SHOW of idx 2 with Enable and Load asserted.
        RST  = 1'b1;
        Load = 1'b1;
        drive_dg(pa);
        step();
        check("midrst anode", 32'(Anode), 32'h0F);
        check("midrst seg", 32'(Seg), 32'h7F);
        check("midrst fsync", 32'(FrameSync), 32'h0);
        check("midrst pending", 32'(Pending), 32'h0);
        RST  = 1'b0;
        Load = 1'b0;
        step();
        // Shadow was cleared by reset, so the whole frame is dark.
        frame("f7", pblank, 1'b0, 99, pnone, 99, pnone);

        for (int i = 0; i < 10; i++) step();
        Enable = 1'b0;
        step();
        check("dis anode", 32'(Anode), 32'h0F);
        check("dis seg", 32'(Seg), 32'h7F);
        check("dis fsync", 32'(FrameSync), 32'h0);
        step();
        check("dis2 anode", 32'(Anode), 32'h0F);

        // Leading-zero pattern loaded in IDLE together with Enable.
        Load   = 1'b1;
        Enable = 1'b1;
        drive_dg(plz);
        step();
        frame("lzb", plz_exp, 1'b0, 99, pnone, 99, pnone);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
